mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative multi-cycle multiply/divide unit that produces the HI/LO results for the register file's special registers. It accepts a MULT/MULTU/DIV/DIVU request with rs/rt operands over a start/busy/done handshake. It computes the 64-bit product or the quotient/remainder in 32 iterations. It then drives the HI/LO write data together with a one-cycle HiWrite/LoWrite pulse.

Parameters:
WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset, sampled on clk rising edge)
start  input  1  request strobe; accepted only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  WIDTH  multiplicand / dividend
rt_data  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress (CALC or FIX)
done  output  1  one-cycle pulse, result valid
HiWrite  output  1  HI write enable to register file, equals done
LoWrite  output  1  LO write enable to register file, equals done
hi_data_in  output  WIDTH  product[63:32] or remainder
lo_data_in  output  WIDTH  product[31:0] or quotient

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; busy, done, HiWrite, LoWrite = 0; hi_data_in, lo_data_in = 0; all internal registers cleared. Reset wins over every other input.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start=1, latch op, rs_data, rt_data; go to CALC with iteration counter=0. Otherwise stay in IDLE.
- Signed ops (MULT, DIV): latch absolute values of both operands; record sign flags.
- CALC, multiply: one shift-add step per cycle on the unsigned 64-bit accumulator.
- CALC, divide: one restoring step per cycle (shift remainder:quotient left, trial subtract divisor, set quotient bit if non-negative).
- CALC lasts exactly WIDTH cycles, then goes to FIX.
- FIX, 1 cycle, sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; give the remainder the sign of the dividend.
- FIX then goes to DONE.
- DONE, 1 cycle: done=HiWrite=LoWrite=1; hi_data_in/lo_data_in show the result. Next state is IDLE.
- Latency: start sampled at edge T; busy=1 for cycles T+1..T+33; done pulse in cycle T+34.
- hi_data_in/lo_data_in change only on entry to DONE (and on reset). They hold the last result until the next DONE.
- start while not in IDLE (CALC, FIX, DONE) is ignored: no queuing, and operands are not re-latched.
- Divide by zero (DIV or DIVU, rt_data=0): lo=all ones, hi=rs_data unchanged. Same latency. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Width rules: all arithmetic is unsigned internally at WIDTH+1 bits for the trial subtract. Negation is two's complement at the result width.
- Reset mid-operation: returns to IDLE next edge. No HiWrite/LoWrite pulse is ever produced for an aborted operation.
- op value is irrelevant outside IDLE.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state encodings S_IDLE, S_CALC, S_FIX, S_DONE
  - helper constant for iteration count
- One sub-module: mdu_div_step, a combinational single restoring-division iteration. Inputs: remainder, quotient, divisor. Outputs: next remainder, next quotient. The top level instantiates it once and iterates over cycles.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge T -> done/HiWrite/LoWrite=1 only in cycle T+34; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15); busy=1 for exactly 33 cycles.
3. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 7/2 -> lo=3, hi=1.
4. DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Start MULTU 6x7. Pulse start with op=DIVU during CALC cycle 5 -> ignored; result hi=0, lo=42, exactly one done pulse.
6. Start MULT, drive rst=0 at CALC cycle 10 -> next edge all outputs 0, state IDLE. No HiWrite/LoWrite pulse over the following 40 cycles. A new start after rst=1 completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the default operand width / iteration count.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = MDU_WIDTH;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift remainder:quotient left by one,
// trial-subtract the divisor and keep the difference when it did not borrow.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder always stays below the divisor, so the top bit of the
  // WIDTH+1 bit difference is exactly the borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, div_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitudes are processed unsigned over
// WIDTH cycles, signs are applied in FIX, and HI/LO are written in DONE.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             HiWrite,
  output logic             LoWrite,
  output logic [WIDTH-1:0] hi_data_in,
  output logic [WIDTH-1:0] lo_data_in
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               div_q, div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_next, quo_next, rem_fix, quo_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // acc holds multiplier (low half) / dividend as quotient seed; opnd holds
  // multiplicand / divisor. Multiplication is commutative, so rs goes low.
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i (acc_q[WIDTH-1:0]),
    .div_i (opnd_q),
    .rem_o (rem_next),
    .quo_o (quo_next)
  );

  always_comb begin
    signed_in = op_is_signed(op);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d   = state_q;
    div_d     = div_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d     = op_is_div(op);
          acc_d     = {{WIDTH{1'b0}}, (signed_in && rs_data[WIDTH-1]) ? -rs_data : rs_data};
          opnd_d    = (signed_in && rt_data[WIDTH-1]) ? -rt_data : rt_data;
          neg_res_d = signed_in && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          neg_rem_d = signed_in && rs_data[WIDTH-1];
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = div_q ? {rem_next, quo_next} : {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          // Divide by zero leaves the dividend as the remainder naturally;
          // only the quotient needs forcing to all ones.
          lo_d = (opnd_q == '0) ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy       = (state_q == S_CALC) || (state_q == S_FIX);
  assign done       = (state_q == S_DONE);
  assign HiWrite    = done;
  assign LoWrite    = done;
  assign hi_data_in = hi_q;
  assign lo_data_in = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops
// checked against plain 64-bit arithmetic.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int DONE_AFTER = 33;  // cyc value of the done cycle minus cyc right after the accepting edge
  localparam int BUSY_LEN = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         busy, done, HiWrite, LoWrite;
  logic [W-1:0] hi_data_in, lo_data_in;

  typedef struct {
    logic [63:0] res;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          busy_cnt = 0;
  int          done_seen = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy       (busy),
    .done       (done),
    .HiWrite    (HiWrite),
    .LoWrite    (LoWrite),
    .hi_data_in (hi_data_in),
    .lo_data_in (lo_data_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          s_a, s_b, q, r;
    longint unsigned u_a, u_b;
    s_a = longint'($signed(a));
    s_b = longint'($signed(b));
    u_a = {32'b0, a};
    u_b = {32'b0, b};
    case (o)
      OP_MULT:  return s_a * s_b;
      OP_MULTU: return u_a * u_b;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
          q = s_a / s_b;
          r = s_a % s_b;
          return {r[31:0], q[31:0]};
        end
        return {32'(u_a % u_b), 32'(u_a / u_b)};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every write strobe must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0 || HiWrite !== 1'b0 || LoWrite !== 1'b0) begin
        chk("strobes", {61'b0, done, HiWrite, LoWrite}, 64'h7);
        chk("busy_in_done", {63'b0, busy}, 64'h0);
        done_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: cycle %0d hi=%h lo=%h, no request pending", cyc, hi_data_in, lo_data_in);
        end else begin
          e = exp_q.pop_front();
          chk("result", {hi_data_in, lo_data_in}, e.res);
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("busy_len", 64'(busy_cnt), 64'(BUSY_LEN));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] res);
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    exp_q.push_back('{res, cyc + DONE_AFTER});
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] res);
    issue(o, a, b, res);
    wait_drain(60);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {60'b0, busy, done, HiWrite, LoWrite}, 64'h0);
    chk("rst_data", {hi_data_in, lo_data_in}, 64'h0);
    rst = 1'b1;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003);
    do_op(OP_DIVU,  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // A start pulse during CALC must be ignored.
    issue(OP_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A);
    n0 = done_seen;
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = OP_DIVU;
    rs_data = 32'd99;
    rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_drain(60);
    repeat (40) @(negedge clk);
    chk("single_done", 64'(done_seen - n0), 64'd1);

    // Reset in the middle of CALC aborts without a write pulse.
    issue(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, 64'h0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("abort_ctrl", {60'b0, busy, done, HiWrite, LoWrite}, 64'h0);
    chk("abort_data", {hi_data_in, lo_data_in}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    n0 = done_seen;
    repeat (40) @(negedge clk);
    chk("abort_pulses", 64'(done_seen - n0), 64'd0);
    do_op(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, model(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98));

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rand_opnd();
      rb = rand_opnd();
      do_op(ro, ra, rb, model(ro, ra, rb));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
